// File: rtl/window3x3_seq.sv
// rtl/window3x3_seq.sv - line-buffer read sequencer producing 3x3 pixel windows
module window3x3_seq #(
    parameter int PIXEL_WIDTH = 8,
    parameter int LINE_WIDTH  = 1920,
    parameter int NUM_LINES   = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          line_done,
    output logic [$clog2(NUM_LINES)-1:0]  rd_line_sel,
    output logic [$clog2(LINE_WIDTH)-1:0] rd_col_sel,
    input  logic [PIXEL_WIDTH-1:0]        rd_pixel,
    output logic [9*PIXEL_WIDTH-1:0]      win_out,
    output logic [$clog2(LINE_WIDTH)-1:0] win_col,
    output logic                          win_valid,
    input  logic                          win_ready,
    output logic                          line_release,
    output logic                          busy,
    output logic                          overflow_err
);

    localparam int PW  = PIXEL_WIDTH;
    localparam int LSW = $clog2(NUM_LINES);
    localparam int CSW = $clog2(LINE_WIDTH);
    localparam int AW  = $clog2(NUM_LINES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EMIT,
        S_RELEASE
    } state_t;

    state_t         state;
    logic [AW-1:0]  lines_avail;
    logic [LSW-1:0] top_line;
    logic [CSW-1:0] col;
    logic [1:0]     phase;
    logic [PW-1:0]  cap0;
    logic [PW-1:0]  cap1;
    // One register per window column; row r lives at [r*PW +: PW].
    logic [3*PW-1:0] win_k0;
    logic [3*PW-1:0] win_k1;
    logic [3*PW-1:0] win_k2;
    logic            emit_last;

    logic [LSW:0]     line_sum;
    logic [LSW-1:0]   fetch_line;
    logic [LSW-1:0]   top_line_next;
    logic [CSW-1:0]   col_next;
    logic             col_is_last;
    logic [3*PW-1:0]  new_col;
    logic [9*PW-1:0]  win_shift;

    // The phase offset is at most 2 and NUM_LINES >= 3, so one subtraction wraps.
    always_comb begin
        line_sum   = {1'b0, top_line} + {{(LSW - 1){1'b0}}, phase};
        fetch_line = line_sum[LSW-1:0];
        if (line_sum >= (LSW + 1)'(NUM_LINES)) begin
            fetch_line = LSW'(line_sum - (LSW + 1)'(NUM_LINES));
        end
    end

    assign rd_line_sel   = (state == S_FETCH) ? fetch_line : top_line;
    assign rd_col_sel    = col;
    assign busy          = (state != S_IDLE);
    assign top_line_next = (top_line == LSW'(NUM_LINES - 1)) ? '0 : top_line + 1'b1;
    assign col_is_last   = (col == CSW'(LINE_WIDTH - 1));
    assign col_next      = col_is_last ? '0 : col + 1'b1;
    assign new_col       = {rd_pixel, cap1, cap0};

    always_comb begin
        win_shift = '0;
        for (int r = 0; r < 3; r++) begin
            win_shift[(r*3+0)*PW +: PW] = win_k1[r*PW +: PW];
            win_shift[(r*3+1)*PW +: PW] = win_k2[r*PW +: PW];
            win_shift[(r*3+2)*PW +: PW] = new_col[r*PW +: PW];
        end
    end

    // Line credit counter: writer adds with line_done, sequencer returns with line_release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lines_avail  <= '0;
            overflow_err <= 1'b0;
        end else begin
            case ({line_done, line_release})
                2'b10: begin
                    if (lines_avail == AW'(NUM_LINES)) begin
                        overflow_err <= 1'b1;
                    end else begin
                        lines_avail <= lines_avail + 1'b1;
                    end
                end
                2'b01: begin
                    if (lines_avail != '0) begin
                        lines_avail <= lines_avail - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            top_line     <= '0;
            col          <= '0;
            phase        <= '0;
            cap0         <= '0;
            cap1         <= '0;
            win_k0       <= '0;
            win_k1       <= '0;
            win_k2       <= '0;
            emit_last    <= 1'b0;
            win_out      <= '0;
            win_col      <= '0;
            win_valid    <= 1'b0;
            line_release <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    col   <= '0;
                    phase <= '0;
                    if (lines_avail >= AW'(3)) begin
                        state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    case (phase)
                        2'd0: begin
                            cap0  <= rd_pixel;
                            phase <= 2'd1;
                        end
                        2'd1: begin
                            cap1  <= rd_pixel;
                            phase <= 2'd2;
                        end
                        default: begin
                            win_k0 <= win_k1;
                            win_k1 <= win_k2;
                            win_k2 <= new_col;
                            phase  <= 2'd0;
                            col    <= col_next;
                            // First two columns of a triple only prime the shift registers.
                            if (col >= CSW'(2)) begin
                                win_out   <= win_shift;
                                win_col   <= col - 1'b1;
                                win_valid <= 1'b1;
                                emit_last <= col_is_last;
                                state     <= S_EMIT;
                            end
                        end
                    endcase
                end
                S_EMIT: begin
                    if (win_ready) begin
                        win_valid <= 1'b0;
                        if (emit_last) begin
                            line_release <= 1'b1;
                            state        <= S_RELEASE;
                        end else begin
                            state <= S_FETCH;
                        end
                    end
                end
                default: begin
                    line_release <= 1'b0;
                    top_line     <= top_line_next;
                    col          <= '0;
                    state        <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_window3x3_seq.sv
// tb/tb_window3x3_seq.sv - scoreboard bench for window3x3_seq (3-line and 5-line rings)
module tb_window3x3_seq;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        ld3, ld5;
    logic [1:0]  rdl3;
    logic [2:0]  rdl5;
    logic [2:0]  rdc3, rdc5;
    logic [7:0]  px3, px5;
    logic [71:0] wo3, wo5;
    logic [2:0]  wc3, wc5;
    logic        wv3, wv5, wr3, wr5, lr3, lr5, busy3, busy5, ov3, ov5;

    logic [7:0] mem3 [0:2][0:7];
    logic [7:0] mem5 [0:4][0:7];
    assign px3 = mem3[rdl3][rdc3];
    assign px5 = mem5[rdl5][rdc5];

    window3x3_seq #(.PIXEL_WIDTH(8), .LINE_WIDTH(8), .NUM_LINES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .line_done(ld3), .rd_line_sel(rdl3), .rd_col_sel(rdc3),
        .rd_pixel(px3), .win_out(wo3), .win_col(wc3), .win_valid(wv3), .win_ready(wr3),
        .line_release(lr3), .busy(busy3), .overflow_err(ov3));

    window3x3_seq #(.PIXEL_WIDTH(8), .LINE_WIDTH(8), .NUM_LINES(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .line_done(ld5), .rd_line_sel(rdl5), .rd_col_sel(rdc5),
        .rd_pixel(px5), .win_out(wo5), .win_col(wc5), .win_valid(wv5), .win_ready(wr5),
        .line_release(lr5), .busy(busy5), .overflow_err(ov5));

    logic [74:0] exp3[$], obs3[$], exp5[$], obs5[$];
    int total = 0;
    int bad = 0;
    int rel3 = 0;
    int rel5 = 0;
    int max_avail5 = 0;
    bit wrap5_seen = 0;
    logic [2:0] prev_rdl5 = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (wv3 && wr3) obs3.push_back({wc3, wo3});
            if (wv5 && wr5) obs5.push_back({wc5, wo5});
            if (lr3) rel3++;
            if (lr5) rel5++;
            if (int'(dut5.lines_avail) > max_avail5) max_avail5 = int'(dut5.lines_avail);
            if (prev_rdl5 == 3'd4 && rdl5 == 3'd0) wrap5_seen = 1;
            prev_rdl5 = rdl5;
        end
    end

    function automatic logic [74:0] mk_win(input int t, input int c);
        logic [71:0] w;
        for (int r = 0; r < 3; r++)
            for (int k = 0; k < 3; k++)
                w[(r*3+k)*8 +: 8] = 8'((t + r) * 16 + (c - 1 + k));
        return {3'(c), w};
    endfunction

    task automatic drive_line(input int d, input int n, input bit wr_mem);
        if (wr_mem) begin
            for (int c = 0; c < 8; c++) begin
                if (d == 3) mem3[n % 3][c] = 8'(n * 16 + c);
                else        mem5[n % 5][c] = 8'(n * 16 + c);
            end
            if (n >= 2) begin
                for (int c = 1; c <= 6; c++) begin
                    if (d == 3) exp3.push_back(mk_win(n - 2, c));
                    else        exp5.push_back(mk_win(n - 2, c));
                end
            end
        end
        @(posedge clk); #1;
        if (d == 3) ld3 = 1'b1; else ld5 = 1'b1;
        @(posedge clk); #1;
        ld3 = 1'b0;
        ld5 = 1'b0;
    endtask

    task automatic wait_obs(input int d, input int n, output bit ok);
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            if ((d == 3 && obs3.size() >= n) || (d == 5 && obs5.size() >= n)) begin
                ok = 1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_rel3(input int n);
        for (int i = 0; i < 200 && rel3 < n; i++) begin
            @(posedge clk); #1;
        end
        total++;
        if (rel3 < n) begin bad++; $display("FAIL rel3_wait got=%0d exp=%0d", rel3, n); end
    endtask

    task automatic test_reset;
        total++;
        if ({wv3, lr3, busy3, ov3, wo3, wc3, rdl3, rdc3} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got valid=%b rel=%b busy=%b ovf=%b win=%h col=%0d line=%0d rcol=%0d exp=all0",
                     wv3, lr3, busy3, ov3, wo3, wc3, rdl3, rdc3);
        end
    endtask

    task automatic test_basic;
        int lat;
        bit ok;
        logic [74:0] e, o;
        drive_line(3, 0, 1);
        drive_line(3, 1, 1);
        drive_line(3, 2, 1);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (wv3) begin lat = i; break; end
        end
        total++;
        if (lat != 10) begin bad++; $display("FAIL latency got=%0d exp=10", lat); end
        wait_obs(3, 6, ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL basic_count got=%0d exp=6", obs3.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                e = exp3.pop_front(); o = obs3.pop_front(); total++;
                if (o !== e) begin bad++; $display("FAIL basic_win%0d got=%h exp=%h", i, o, e); end
            end
        end
        wait_rel3(1);
        repeat (3) @(posedge clk); #1;
        total++;
        if (rdl3 !== 2'd1 || busy3 !== 1'b0 || rel3 != 1) begin
            bad++; $display("FAIL basic_release got top=%0d busy=%b rel=%0d exp top=1 busy=0 rel=1", rdl3, busy3, rel3);
        end
    endtask

    task automatic test_line_rotation;
        bit ok;
        logic [74:0] e, o;
        drive_line(3, 3, 1);
        wait_obs(3, 6, ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL rot_count got=%0d exp=6", obs3.size());
        end else begin
            total++;
            if (obs3[0][7:0] !== 8'h10 || obs3[0][55:48] !== 8'h30) begin
                bad++; $display("FAIL rot_rows got top=%h bottom=%h exp top=10 bottom=30", obs3[0][7:0], obs3[0][55:48]);
            end
            for (int i = 0; i < 6; i++) begin
                e = exp3.pop_front(); o = obs3.pop_front(); total++;
                if (o !== e) begin bad++; $display("FAIL rot_win%0d got=%h exp=%h", i, o, e); end
            end
        end
        wait_rel3(2);
    endtask

    task automatic test_back_pressure;
        int stall;
        logic [74:0] held, e, o;
        stall = 0;
        held = '0;
        drive_line(3, 4, 1);
        for (int cyc = 0; cyc < 300 && obs3.size() < 6; cyc++) begin
            @(posedge clk); #1;
            if (wv3 && wc3 == 3'd3 && stall < 5) begin
                if (stall == 0) begin
                    held = {wc3, wo3};
                    total++;
                    if (held !== mk_win(2, 3)) begin bad++; $display("FAIL stall_win got=%h exp=%h", held, mk_win(2, 3)); end
                end else begin
                    total++;
                    if ({wc3, wo3} !== held) begin bad++; $display("FAIL stall_hold%0d got=%h exp=%h", stall, {wc3, wo3}, held); end
                end
                wr3 = 1'b0;
                stall++;
            end else begin
                wr3 = 1'b1;
            end
        end
        wr3 = 1'b1;
        total++;
        if (stall != 5 || obs3.size() != 6) begin
            bad++; $display("FAIL stall_progress got stalls=%0d windows=%0d exp stalls=5 windows=6", stall, obs3.size());
        end
        while (obs3.size() > 0 && exp3.size() > 0) begin
            e = exp3.pop_front(); o = obs3.pop_front(); total++;
            if (o !== e) begin bad++; $display("FAIL bp_win got=%h exp=%h", o, e); end
        end
        wait_rel3(3);
        repeat (5) @(posedge clk); #1;
        total++;
        if (obs3.size() != 0 || exp3.size() != 0) begin
            bad++; $display("FAIL bp_leftover got obs=%0d exp_left=%0d exp 0/0", obs3.size(), exp3.size());
        end
    endtask

    task automatic test_wrap5;
        bit ok;
        logic [74:0] e, o;
        for (int n = 0; n < 7; n++) begin
            for (int i = 0; i < 500 && (n - rel5) >= 5; i++) begin
                @(posedge clk); #1;
            end
            drive_line(5, n, 1);
        end
        for (int i = 0; i < 2000 && rel5 < 5; i++) begin
            @(posedge clk); #1;
        end
        repeat (4) @(posedge clk); #1;
        total++;
        if (rel5 != 5) begin bad++; $display("FAIL wrap_releases got=%0d exp=5", rel5); end
        wait_obs(5, 30, ok);
        total++;
        if (!ok || obs5.size() != 30) begin
            bad++; $display("FAIL wrap_count got=%0d exp=30", obs5.size());
        end else begin
            for (int i = 0; i < 30; i++) begin
                e = exp5.pop_front(); o = obs5.pop_front(); total++;
                if (o !== e) begin bad++; $display("FAIL wrap_win%0d got=%h exp=%h", i, o, e); end
            end
        end
        total++;
        if (max_avail5 > 5 || !wrap5_seen || ov5 !== 1'b0) begin
            bad++; $display("FAIL wrap_flags got max=%0d wrap=%b ovf=%b exp max<=5 wrap=1 ovf=0", max_avail5, wrap5_seen, ov5);
        end
    endtask

    task automatic test_overflow;
        wr3 = 1'b0;
        drive_line(3, 5, 1);
        for (int i = 0; i < 40 && !wv3; i++) begin
            @(posedge clk); #1;
        end
        drive_line(3, 6, 0);
        total++;
        if (dut3.lines_avail !== 2'd3 || ov3 !== 1'b1) begin
            bad++; $display("FAIL overflow_set got avail=%0d ovf=%b exp avail=3 ovf=1", dut3.lines_avail, ov3);
        end
        repeat (5) @(posedge clk); #1;
        total++;
        if (dut3.lines_avail !== 2'd3 || ov3 !== 1'b1 || wv3 !== 1'b1) begin
            bad++; $display("FAIL overflow_sticky got avail=%0d ovf=%b valid=%b exp 3/1/1", dut3.lines_avail, ov3, wv3);
        end
    endtask

    task automatic test_mid_reset;
        bit ok;
        logic [74:0] e, o;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        total++;
        if ({wv3, lr3, busy3, ov3} !== 4'b0) begin
            bad++; $display("FAIL async_reset got valid=%b rel=%b busy=%b ovf=%b exp 0000", wv3, lr3, busy3, ov3);
        end
        exp3.delete();
        obs3.delete();
        rel3 = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        wr3 = 1'b1;
        repeat (3) @(posedge clk); #1;
        total++;
        if (rel3 != 0 || busy3 !== 1'b0) begin
            bad++; $display("FAIL post_reset_idle got rel=%0d busy=%b exp 0/0", rel3, busy3);
        end
        drive_line(3, 0, 1);
        drive_line(3, 1, 1);
        drive_line(3, 2, 1);
        wait_obs(3, 6, ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL reset_count got=%0d exp=6", obs3.size());
        end else begin
            total++;
            if (obs3[0][74:72] !== 3'd1) begin bad++; $display("FAIL reset_first_col got=%0d exp=1", obs3[0][74:72]); end
            for (int i = 0; i < 6; i++) begin
                e = exp3.pop_front(); o = obs3.pop_front(); total++;
                if (o !== e) begin bad++; $display("FAIL reset_win%0d got=%h exp=%h", i, o, e); end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        ld3 = 1'b0; ld5 = 1'b0;
        wr3 = 1'b1; wr5 = 1'b1;
        for (int l = 0; l < 3; l++) for (int c = 0; c < 8; c++) mem3[l][c] = '0;
        for (int l = 0; l < 5; l++) for (int c = 0; c < 8; c++) mem5[l][c] = '0;
        repeat (3) @(posedge clk); #1;
        test_reset;
        rst_n = 1'b1;
        test_basic;
        test_line_rotation;
        test_back_pressure;
        test_wrap5;
        test_overflow;
        test_mid_reset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/window3x3_seq.md
Name: window3x3_seq

Overview:
Downstream read sequencer for the line buffer. It tracks how many complete lines the buffer holds and walks the three oldest lines column by column over the buffer's combinational read port. From those reads it builds 3x3 pixel windows and streams them out on a valid/ready interface to convolution and filter stages. It returns each consumed line to the writer side through a release pulse, which works as a line credit.

Parameters:
PIXEL_WIDTH, 8, bits per pixel (must match line buffer)
LINE_WIDTH, 1920, pixels per line (>=3)
NUM_LINES, 3, line-buffer ring depth (>=3)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
line_done  input  1  one-cycle pulse: line buffer finished writing one full line
rd_line_sel  output  $clog2(NUM_LINES)  line-buffer read line index
rd_col_sel  output  $clog2(LINE_WIDTH)  line-buffer read column index
rd_pixel  input  PIXEL_WIDTH  line-buffer read data, combinational, same cycle as rd_*
win_out  output  9*PIXEL_WIDTH  window; element (r,k) at [(r*3+k)*PIXEL_WIDTH +: PIXEL_WIDTH]; r=0 is oldest row, k=0 is leftmost column
win_col  output  $clog2(LINE_WIDTH)  centre column of win_out
win_valid  output  1  window valid
win_ready  input  1  consumer accepts window
line_release  output  1  one-cycle pulse: oldest line freed, writer may overwrite it
busy  output  1  FSM not in IDLE
overflow_err  output  1  sticky: line_done arrived while lines_avail==NUM_LINES

Behaviour:
- Clock and reset: single clock clk. rst_n is asynchronous and active-low.
- Reset values: all outputs 0, FSM IDLE, lines_avail=0, top_line=0, col=0, phase=0, column registers 0.
- lines_avail, range 0..NUM_LINES:
  - +1 on line_done; -1 on line_release; both in the same cycle leaves it unchanged.
  - line_done at NUM_LINES (without release) saturates the count and sets overflow_err; only reset clears overflow_err.
- Read addressing (combinational from state registers):
  - rd_line_sel = (top_line+phase) mod NUM_LINES; rd_col_sel = col.
  - Outside FETCH: rd_line_sel=top_line, rd_col_sel=col.
- IDLE:
  - busy=0. Go to FETCH when lines_avail>=3.
  - col=0, phase=0 on entry.
- FETCH:
  - One cycle per phase 0,1,2. rd_pixel is captured into column register C[phase] at the end of each cycle.
  - At the end of phase 2, the window shifts left by one column: k0<=k1, k1<=k2, k2<={C0,C1,C2 with the phase 2 pixel}. Then col increments and phase resets to 0.
  - If the column just fetched was >=2: load win_out with the shifted window, set win_col=that column-1, raise win_valid, go to EMIT.
  - Otherwise stay in FETCH.
- EMIT:
  - win_valid=1. win_out and win_col are held stable until win_ready=1 (transfer on valid&&ready).
  - On transfer, win_valid drops next cycle:
    - if the fetched column was LINE_WIDTH-1, go to RELEASE;
    - otherwise go to FETCH.
  - No combinational ready-to-valid path.
- RELEASE:
  - One cycle with line_release=1; top_line <= (top_line+1) mod NUM_LINES; col=0.
  - Next state IDLE, which re-enters FETCH on the next cycle if lines_avail (post-decrement) >=3.
- Window count and borders:
  - No border padding: each line triple yields exactly LINE_WIDTH-2 windows, win_col 1..LINE_WIDTH-2, in increasing order.
  - Column shift registers are not cleared between triples; the first two fetched columns refill them.
- Timing:
  - Throughput: at most 1 window per 4 clocks (3 FETCH + 1 EMIT when win_ready is high).
  - Latency: from the edge that samples the line_done making lines_avail=3 while IDLE, win_valid rises after the 10th subsequent edge (1 IDLE + 9 FETCH cycles).
- Wrap-around: top_line and rd_line_sel wrap modulo NUM_LINES, including when NUM_LINES is not a power of two.
- line_done accepted in any state, including during FETCH/EMIT/RELEASE.
- Reset mid-operation: immediate return to reset values; any pending window is dropped; no line_release issued.

Test Plan:
1. LINE_WIDTH=8, NUM_LINES=3, pixel(line,col)=line*16+col, win_ready=1, three line_done pulses -> 6 windows, win_col 1..6. First window rows {00,01,02},{10,11,12},{20,21,22}; win_valid rises 10 clocks after the third line_done; then one line_release pulse and top_line=1.
2. Same setup with win_ready low for 5 cycles on window 3 -> win_out/win_col (=3) held stable, no window lost or duplicated, total 6 windows in order.
3. Fourth line_done after test 1 release (lines 1,2,0 in rows r0..r2) -> next window rows come from line indices 1,2,0; top row first pixel value matches line 1 contents.
4. NUM_LINES=5, stream 7 lines -> 5 release pulses, rd_line_sel wraps 4->0, lines_avail never exceeds 5, overflow_err stays 0.
5. NUM_LINES=3, fourth line_done without any release (win_ready=0 stall) -> lines_avail stays 3, overflow_err=1 and sticky.
6. Assert rst_n low mid-EMIT -> win_valid, line_release, busy, overflow_err all 0 immediately; after release and three new line_done pulses, normal output from win_col=1.
